i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target (responder) for the same single-master bus that the team's I2C master drives.
- Oversamples SCL/SDA on the system clock. Detects START/STOP and matches a 7-bit address.
- Write transfers: receives bytes, ACKs each one, presents them on a byte strobe interface.
- Read transfers: fetches bytes from the user, shifts them out, and reports the master's ACK/NACK.
- Standard mode, no clock stretching, no general call, no 10-bit addressing.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- reset  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock, asynchronous to clk.
- sda  inout  1  bus data, open-drain. Driven only as 1'b0 or 1'bz; a 1 is never driven.
- rx_data  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-clk pulse; rx_data is new.
- tx_data  input  8  next byte to transmit in a read transfer.
- tx_req  output  1  one-clk pulse; user must present tx_data.
- busy  output  1  high from address match until STOP or non-matching end.
- rw  output  1  R/W bit of the current transfer (1 = read).
- start_det  output  1  one-clk pulse on START or repeated START.
- stop_det  output  1  one-clk pulse on STOP.
- nack_rcvd  output  1  one-clk pulse when the master NACKs a read byte.

Behaviour:
- Reset: state=IDLE, sda released (z). rx_data=0, rx_valid=0, tx_req=0, busy=0, rw=0, start_det=0, stop_det=0, nack_rcvd=0.
- Reset asserted mid-transfer releases sda immediately; it acts asynchronously on the output-enable register.
- Input path: scl/sda each pass through a 2-FF synchronizer plus one history FF.
- Edge and condition detection uses synchronized values only:
  - SCL rise/fall = sync != history.
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Detection latency: 3 clk after the pin edge.
- START/STOP take priority over every state, including mid-byte and during ACK:
  - START: pulse start_det, clear bit counter, release sda, go to ADDR. Busy stays set if already set (repeated START).
  - STOP: pulse stop_det, release sda, clear busy, go to IDLE.
- Bits are sampled on synchronized SCL rise. sda changes only on synchronized SCL fall.
- States:
  - IDLE: sda released; wait for START.
  - ADDR: shift 8 bits MSB first.
    - After the 8th rise: if byte[7:1]==SLAVE_ADDR, latch rw=byte[0], set busy, go to ADDR_ACK.
    - Otherwise go to IGNORE and never drive sda.
  - ADDR_ACK:
    - On the SCL fall after the 8th bit, drive sda low.
    - If rw=1, pulse tx_req on that same fall.
    - On the next SCL fall: rw=0 releases sda and goes to WR_BYTE; rw=1 loads shifter with tx_data, drives bit7, and goes to RD_BYTE.
  - WR_BYTE: shift 8 bits. On the 8th rise, update rx_data and pulse rx_valid in the same clk, then go to WR_ACK.
  - WR_ACK: drive sda low from the following SCL fall until the next SCL fall; then release and go to WR_BYTE.
  - RD_BYTE:
    - On each SCL fall, drive the next bit: sda=z for 1, 0 for 0.
    - After the 8th bit's fall, release sda and go to RD_ACK.
  - RD_ACK: sample sda on the SCL rise.
    - ACK (0): pulse tx_req. At the next SCL fall, load tx_data and drive its bit7; go to RD_BYTE.
    - NACK (1): pulse nack_rcvd, go to IGNORE.
  - IGNORE: sda released; wait for START or STOP.
- tx_data is sampled exactly one SCL low-phase after tx_req (≥ 8 clk). The user must hold it stable from tx_req+2 clk until the load.
- The bit counter is 3 bits and wraps 7→0 on every byte. Multi-byte transfers are unbounded.
- If the user ignores rx_valid, rx_data is simply overwritten. Writes are always ACKed.
- START is never mistaken for data: SDA changes while SCL is high are only ever START/STOP.

Test Plan:
- Write: START, 0xA0, 0x3C, 0xF0, STOP → ACK low on all 3 ninth clocks; rx_valid twice (0x3C then 0xF0); busy 1 from address ACK to stop_det; rw=0.
- Read: START, 0xA1, user answers tx_req with 0x96 then 0x5A; master ACKs byte 1, NACKs byte 2, STOP → bus bits 10010110 and 01011010; tx_req twice; nack_rcvd once; sda released after NACK.
- Mismatch: START, 0xA2, 0x11, STOP → sda never driven low; no rx_valid; busy stays 0; start_det and stop_det each pulse once.
- Repeated START: write 0xA0, 0x07, then Sr, 0xA1, read 1 byte NACK, STOP → rx_data=0x07; rw switches 0→1; start_det pulses twice; busy continuous until STOP.
- Abort: STOP after 4 bits of a write data byte → no rx_valid; state IDLE. A following full write of 0x55 is received correctly.
- Reset mid-read while driving a 0 bit → sda goes z in the same clk edge; all outputs hold reset values; the next transaction works normally.

Source files
------------

// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - user-side byte and status interface of the I2C target
interface i2c_slave_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic       rw;
  logic       start_det;
  logic       stop_det;
  logic       nack_rcvd;

  modport slave (
    output rx_data, rx_valid, tx_req, busy, rw, start_det, stop_det, nack_rcvd,
    input  tx_data
  );

  modport master (
    input  rx_data, rx_valid, tx_req, busy, rw, start_det, stop_det, nack_rcvd,
    output tx_data
  );
endinterface

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - oversampling 7-bit-address I2C target with byte strobe user side
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  i2c_slave_if.slave user
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t     state, state_n;
  logic       scl_meta, scl_sync, scl_hist;
  logic       sda_meta, sda_sync, sda_hist;
  logic       scl_rise, scl_fall, start_cond, stop_cond;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, shift_in;
  logic       phase, phase_n;
  logic       sda_oe, sda_oe_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, tx_req_n, busy_n, rw_n;
  logic       start_det_n, stop_det_n, nack_rcvd_n;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Synchronizers reset to the idle-bus level so no edge is seen out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_hist <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_meta <= scl;
      scl_sync <= scl_meta;
      scl_hist <= scl_sync;
      sda_meta <= sda;
      sda_sync <= sda_meta;
      sda_hist <= sda_sync;
    end
  end

  assign scl_rise   =  scl_sync & ~scl_hist;
  assign scl_fall   = ~scl_sync &  scl_hist;
  assign start_cond =  scl_sync &  scl_hist &  sda_hist & ~sda_sync;
  assign stop_cond  =  scl_sync &  scl_hist & ~sda_hist &  sda_sync;
  assign shift_in   = {shift[6:0], sda_sync};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= 3'd0;
      shift          <= 8'h00;
      phase          <= 1'b0;
      sda_oe         <= 1'b0;
      user.rx_data   <= 8'h00;
      user.rx_valid  <= 1'b0;
      user.tx_req    <= 1'b0;
      user.busy      <= 1'b0;
      user.rw        <= 1'b0;
      user.start_det <= 1'b0;
      user.stop_det  <= 1'b0;
      user.nack_rcvd <= 1'b0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      shift          <= shift_n;
      phase          <= phase_n;
      sda_oe         <= sda_oe_n;
      user.rx_data   <= rx_data_n;
      user.rx_valid  <= rx_valid_n;
      user.tx_req    <= tx_req_n;
      user.busy      <= busy_n;
      user.rw        <= rw_n;
      user.start_det <= start_det_n;
      user.stop_det  <= stop_det_n;
      user.nack_rcvd <= nack_rcvd_n;
    end
  end

  // phase marks the second half of an ACK slot: 0 = waiting for the fall that
  // starts the ACK bit, 1 = waiting for the fall that ends it.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    phase_n     = phase;
    sda_oe_n    = sda_oe;
    rx_data_n   = user.rx_data;
    busy_n      = user.busy;
    rw_n        = user.rw;
    rx_valid_n  = 1'b0;
    tx_req_n    = 1'b0;
    start_det_n = 1'b0;
    stop_det_n  = 1'b0;
    nack_rcvd_n = 1'b0;

    if (start_cond) begin
      start_det_n = 1'b1;
      bit_cnt_n   = 3'd0;
      phase_n     = 1'b0;
      sda_oe_n    = 1'b0;
      state_n     = ADDR;
    end else if (stop_cond) begin
      stop_det_n  = 1'b1;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b0;
      state_n     = IDLE;
    end else begin
      case (state)
        IDLE, IGNORE: begin
          sda_oe_n = 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shift_in[7:1] == SLAVE_ADDR) begin
                rw_n    = shift_in[0];
                busy_n  = 1'b1;
                phase_n = 1'b0;
                state_n = ADDR_ACK;
              end else begin
                busy_n  = 1'b0;
                state_n = IGNORE;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_n = 1'b1;
              phase_n  = 1'b1;
              tx_req_n = user.rw;
            end else begin
              bit_cnt_n = 3'd0;
              phase_n   = 1'b0;
              if (user.rw) begin
                shift_n  = user.tx_data;
                sda_oe_n = ~user.tx_data[7];
                state_n  = RD_BYTE;
              end else begin
                sda_oe_n = 1'b0;
                state_n  = WR_BYTE;
              end
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_n  = shift_in;
              rx_valid_n = 1'b1;
              phase_n    = 1'b0;
              state_n    = WR_ACK;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_n = 1'b1;
              phase_n  = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              phase_n   = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = WR_BYTE;
            end
          end
        end

        // bit_cnt counts bits already placed on the bus; bit 7 went out on entry.
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n = 1'b0;
              phase_n  = 1'b0;
              state_n  = RD_ACK;
            end else begin
              shift_n   = {shift[6:0], 1'b0};
              sda_oe_n  = ~shift[6];
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end

        RD_ACK: begin
          if (!phase) begin
            if (scl_rise) begin
              if (!sda_sync) begin
                tx_req_n = 1'b1;
                phase_n  = 1'b1;
              end else begin
                nack_rcvd_n = 1'b1;
                state_n     = IGNORE;
              end
            end
          end else if (scl_fall) begin
            shift_n   = user.tx_data;
            sda_oe_n  = ~user.tx_data[7];
            bit_cnt_n = 3'd0;
            phase_n   = 1'b0;
            state_n   = RD_BYTE;
          end
        end

        default: begin
          sda_oe_n = 1'b0;
          state_n  = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - randomized self-checking bench for the I2C target
module tb_i2c_slave;
  localparam logic [6:0] ADDR = 7'h50;
  localparam int Q = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_if u ();

  i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
    .clk   (clk),
    .reset (reset),
    .scl   (scl),
    .sda   (sda),
    .user  (u)
  );

  int errors = 0;
  int checks = 0;
  int n_txreq = 0, n_start = 0, n_stop = 0, n_nack = 0, n_busy_fall = 0, slave_low = 0;
  logic [7:0] got_rx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  logic [7:0] payload[$];

  initial forever #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // User side: logs received bytes, answers tx_req from tx_q, counts pulses.
  initial begin
    logic busy_q;
    busy_q    = 1'b0;
    u.tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (u.rx_valid) got_rx.push_back(u.rx_data);
      if (u.tx_req) begin
        n_txreq++;
        if (tx_q.size() > 0) u.tx_data = tx_q.pop_front();
        else u.tx_data = 8'($urandom);
      end
      if (u.start_det) n_start++;
      if (u.stop_det) n_stop++;
      if (u.nack_rcvd) n_nack++;
      if (busy_q && !u.busy) n_busy_fall++;
      busy_q = u.busy;
      if (sda === 1'b0 && !m_low) slave_low++;
    end
  end

  task automatic write_bit(input logic b);
    m_low = ~b;
    #(Q); scl = 1'b1;
    #(2*Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); b = sda;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; scl = 1'b1;
    #(Q); m_low = 1'b1;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); m_low = 1'b1;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    #(Q); scl = 1'b1;
    #(Q); m_low = 1'b0;
    #(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(nack);
  endtask

  // Reference behaviour: only address ADDR responds; writes are all ACKed and
  // delivered in order; reads return the user bytes, last one NACKed by master.
  task automatic body(input logic [7:0] ab, input int n);
    logic       ack;
    logic [7:0] got;
    bit         m;
    m = (ab[7:1] == ADDR);
    if (m && ab[0]) tx_q = payload;
    write_byte(ab, ack);
    check("addr_ack", 32'(ack), 32'(!m));
    check("busy_after_addr", 32'(u.busy), 32'(m));
    if (m) check("rw_latched", 32'(u.rw), 32'(ab[0]));
    for (int i = 0; i < n; i++) begin
      if (m && ab[0]) begin
        read_byte(got, i == n - 1);
        check("rd_byte", 32'(got), 32'(payload[i]));
      end else begin
        write_byte(payload[i], ack);
        check("wr_ack", 32'(ack), 32'(!m));
        if (m) exp_rx.push_back(payload[i]);
      end
    end
  endtask

  task automatic compare_rx();
    check("rx_count", 32'(got_rx.size()), 32'(exp_rx.size()));
    for (int i = 0; i < got_rx.size() && i < exp_rx.size(); i++)
      check("rx_byte", 32'(got_rx[i]), 32'(exp_rx[i]));
    got_rx.delete();
    exp_rx.delete();
  endtask

  initial begin
    logic       ack;
    logic [6:0] a;
    logic       rd;
    int         n, s_start, s_stop, s_nack, s_tx, s_bf, s_low;

    #43;
    check("rst_sda", 32'(sda), 32'(1'b1));
    check("rst_rx_data", 32'(u.rx_data), 32'h0);
    check("rst_rx_valid", 32'(u.rx_valid), 32'h0);
    check("rst_tx_req", 32'(u.tx_req), 32'h0);
    check("rst_busy", 32'(u.busy), 32'h0);
    check("rst_rw", 32'(u.rw), 32'h0);
    check("rst_start_det", 32'(u.start_det), 32'h0);
    check("rst_stop_det", 32'(u.stop_det), 32'h0);
    check("rst_nack_rcvd", 32'(u.nack_rcvd), 32'h0);
    reset = 1'b0;
    #(2*Q);

    // Plain write of two bytes.
    s_start = n_start; s_stop = n_stop; s_bf = n_busy_fall;
    payload = '{8'h3C, 8'hF0};
    i2c_start();
    body(8'hA0, 2);
    check("wr_busy_before_stop", 32'(u.busy), 32'h1);
    i2c_stop();
    check("wr_start_cnt", 32'(n_start - s_start), 32'd1);
    check("wr_stop_cnt", 32'(n_stop - s_stop), 32'd1);
    check("wr_busy_fall", 32'(n_busy_fall - s_bf), 32'd1);
    check("wr_busy_end", 32'(u.busy), 32'h0);
    compare_rx();

    // Read of two bytes, ACK then NACK.
    s_tx = n_txreq; s_nack = n_nack;
    payload = '{8'h96, 8'h5A};
    i2c_start();
    body(8'hA1, 2);
    check("rd_txreq_cnt", 32'(n_txreq - s_tx), 32'd2);
    check("rd_nack_cnt", 32'(n_nack - s_nack), 32'd1);
    check("rd_sda_released", 32'(sda), 32'h1);
    i2c_stop();
    compare_rx();

    // Address mismatch: target must stay silent.
    s_start = n_start; s_stop = n_stop; s_low = slave_low;
    payload = '{8'h11};
    i2c_start();
    body(8'hA2, 1);
    i2c_stop();
    check("mm_slave_low", 32'(slave_low - s_low), 32'd0);
    check("mm_start_cnt", 32'(n_start - s_start), 32'd1);
    check("mm_stop_cnt", 32'(n_stop - s_stop), 32'd1);
    check("mm_busy", 32'(u.busy), 32'h0);
    compare_rx();

    // Write then repeated START into a read.
    s_start = n_start; s_bf = n_busy_fall;
    payload = '{8'h07};
    i2c_start();
    body(8'hA0, 1);
    i2c_rstart();
    payload = '{8'($urandom)};
    body(8'hA1, 1);
    check("rs_busy_before_stop", 32'(u.busy), 32'h1);
    i2c_stop();
    check("rs_rx_data", 32'(u.rx_data), 32'h07);
    check("rs_start_cnt", 32'(n_start - s_start), 32'd2);
    check("rs_busy_fall", 32'(n_busy_fall - s_bf), 32'd1);
    compare_rx();

    // STOP in the middle of a data byte.
    s_stop = n_stop;
    i2c_start();
    write_byte(8'hA0, ack);
    check("ab_addr_ack", 32'(ack), 32'h0);
    for (int i = 0; i < 4; i++) write_bit(1'($urandom));
    i2c_stop();
    check("ab_stop_cnt", 32'(n_stop - s_stop), 32'd1);
    check("ab_busy", 32'(u.busy), 32'h0);
    compare_rx();
    payload = '{8'h55};
    i2c_start();
    body(8'hA0, 1);
    i2c_stop();
    compare_rx();

    // Reset while the target drives a 0 bit of a read.
    tx_q = '{8'h3F};
    i2c_start();
    write_byte(8'hA1, ack);
    check("rr_addr_ack", 32'(ack), 32'h0);
    check("rr_driving_zero", 32'(sda), 32'h0);
    reset = 1'b1;
    #1;
    check("rr_sda_released", 32'(sda), 32'h1);
    check("rr_rx_data", 32'(u.rx_data), 32'h0);
    check("rr_busy", 32'(u.busy), 32'h0);
    check("rr_rw", 32'(u.rw), 32'h0);
    check("rr_tx_req", 32'(u.tx_req), 32'h0);
    #50;
    reset = 1'b0;
    tx_q.delete();
    scl = 1'b1;
    #(2*Q);
    payload = '{8'($urandom)};
    i2c_start();
    body(8'hA0, 1);
    i2c_stop();
    compare_rx();

    // Randomized transactions against the reference behaviour.
    for (int k = 0; k < 8; k++) begin
      a  = ($urandom_range(0, 3) != 0) ? ADDR : 7'($urandom);
      rd = 1'($urandom);
      n  = $urandom_range(1, 4);
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
      s_start = n_start; s_stop = n_stop; s_tx = n_txreq; s_nack = n_nack;
      i2c_start();
      body({a, rd}, n);
      i2c_stop();
      check("rnd_start_cnt", 32'(n_start - s_start), 32'd1);
      check("rnd_stop_cnt", 32'(n_stop - s_stop), 32'd1);
      check("rnd_txreq_cnt", 32'(n_txreq - s_tx), (a == ADDR && rd) ? 32'(n) : 32'd0);
      check("rnd_nack_cnt", 32'(n_nack - s_nack), (a == ADDR && rd) ? 32'd1 : 32'd0);
      check("rnd_busy_end", 32'(u.busy), 32'h0);
      compare_rx();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
